// File: rtl/mmm_mod_inverse.sv
// rtl/mmm_mod_inverse.sv - Hensel-lifting modular inverse modulo 2^k for Montgomery set-up
module mmm_mod_inverse #(
  parameter int IDW = 256,
  parameter int ODW = IDW + 3,
  parameter int N   = 256,
  parameter int NW  = $clog2(N),
  parameter int PW  = 260,
  parameter bit MOD = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_en,
  input  logic [IDW-1:0]   i_a,
  input  logic [PW-1:0]    i_p,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [ODW-1:0]   o_m_b
);

  // Accumulator holds s in [-1, a]; s + a needs one bit above a plus a sign bit.
  localparam int SW  = N + 2;
  // Bit-count / iteration index width; must hold values up to ODW = N + 3.
  localparam int KW  = NW + 1;
  // Width of a bit index into i_p.
  localparam int PIW = $clog2(PW);

  // +1 seeds a*y + 1 == s*2^cnt (negated inverse); -1 seeds a*y - 1 == s*2^cnt.
  localparam logic signed [SW-1:0] S_INIT =
    MOD ? {{(SW-1){1'b0}}, 1'b1} : {SW{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [IDW-1:0]        a;
  logic signed [SW-1:0]  s;
  logic [ODW-1:0]        y;
  logic [KW-1:0]         k;
  logic [KW-1:0]         cnt;

  logic [PIW-1:0]        p_msb;
  logic [KW-1:0]         k_start;
  logic signed [SW-1:0]  s_sum;
  logic signed [SW-1:0]  s_next;

  // Position of the highest set bit of the modulus; zero modulus maps to index 0.
  always_comb begin
    p_msb = '0;
    for (int i = 0; i < PW; i++) begin
      if (i_p[i]) begin
        p_msb = PIW'(i);
      end
    end
  end

  // Clamp the bit count to the result width so every result bit has a home.
  always_comb begin
    k_start = '0;
    if (int'(p_msb) > ODW) begin
      k_start = KW'(ODW);
    end else begin
      k_start = KW'(p_msb);
    end
  end

  // One Hensel step: add a whenever the low bit is set so the sum is even, then halve.
  always_comb begin
    s_sum  = s + (s[0] ? $signed({{(SW-IDW){1'b0}}, a}) : {SW{1'b0}});
    s_next = s_sum >>> 1;
  end

  // Control FSM and datapath registers; outputs are registered and only change in DONE.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= IDLE;
      a       <= '0;
      s       <= '0;
      y       <= '0;
      k       <= '0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_m_b   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_en) begin
            a     <= i_a;
            k     <= k_start;
            y     <= '0;
            s     <= S_INIT;
            cnt   <= '0;
            state <= (k_start == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          y[cnt] <= s[0];
          s      <= s_next;
          cnt    <= cnt + KW'(1);
          if (cnt == k - KW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!o_valid) begin
            o_valid <= 1'b1;
            o_m_b   <= y;
          end else if (i_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmm_mod_inverse.sv
// tb/tb_mmm_mod_inverse.sv - directed-vector bench for mmm_mod_inverse
module tb_mmm_mod_inverse;

  localparam int IDW = 256;
  localparam int ODW = IDW + 3;
  localparam int PW  = 260;
  localparam int NV  = 13;

  logic             clk;
  logic             rstn;
  logic             en1;
  logic             en0;
  logic [IDW-1:0]   a_in;
  logic [PW-1:0]    p_in;
  logic             ready;
  logic             valid1;
  logic             valid0;
  logic [ODW-1:0]   mb1;
  logic [ODW-1:0]   mb0;

  logic             use0;
  logic             obs_valid;
  logic [ODW-1:0]   obs_mb;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [IDW-1:0] a;
    logic [PW-1:0]  p;
    logic [ODW-1:0] m;
    int             lat;
    bit             plain;
  } vec_t;

  vec_t vecs [NV];

  mmm_mod_inverse #(.MOD(1'b1)) dut1 (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_en    (en1),
    .i_a     (a_in),
    .i_p     (p_in),
    .i_ready (ready),
    .o_valid (valid1),
    .o_m_b   (mb1)
  );

  mmm_mod_inverse #(.MOD(1'b0)) dut0 (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_en    (en0),
    .i_a     (a_in),
    .i_p     (p_in),
    .i_ready (ready),
    .o_valid (valid0),
    .o_m_b   (mb0)
  );

  assign obs_valid = use0 ? valid0 : valid1;
  assign obs_mb    = use0 ? mb0 : mb1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_v(input string nm, input logic [ODW-1:0] act, input logic [ODW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_i(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Starts an operation (called #1 after a rising edge) and waits for o_valid.
  task automatic run_op(input logic [IDW-1:0] av, input logic [PW-1:0] pv,
                        output logic [ODW-1:0] res, output int cyc);
    a_in = av;
    p_in = pv;
    if (use0) en0 = 1'b1; else en1 = 1'b1;
    @(posedge clk); #1;
    en0 = 1'b0;
    en1 = 1'b0;
    cyc = 0;
    while (!obs_valid && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
    end
    res = obs_mb;
  endtask

  task automatic accept(input string nm);
    ready = 1'b1;
    @(posedge clk); #1;
    check_v(nm, {{(ODW-1){1'b0}}, obs_valid}, '0);
    ready = 1'b0;
  endtask

  logic [PW-1:0]  p1;
  logic [ODW-1:0] o1;
  logic [ODW-1:0] res;
  logic [ODW-1:0] held;
  int             cyc;
  bit             stable;
  bit             seen;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    p1 = 1;
    o1 = 1;

    vecs[0]  = '{a: 256'd3,          p: p1 << 8,   m: 259'h55,            lat: 9,   plain: 1'b0};
    vecs[1]  = '{a: 256'd3,          p: p1 << 8,   m: 259'hAB,            lat: 9,   plain: 1'b1};
    vecs[2]  = '{a: 256'd1,          p: p1 << 259, m: {ODW{1'b1}},        lat: 260, plain: 1'b0};
    vecs[3]  = '{a: {IDW{1'b1}},     p: p1 << 259, m: (o1 << 256) | o1,   lat: 260, plain: 1'b0};
    vecs[4]  = '{a: 256'd1,          p: '0,        m: '0,                 lat: 1,   plain: 1'b0};
    vecs[5]  = '{a: 256'd3,          p: p1 << 1,   m: 259'h1,             lat: 2,   plain: 1'b0};
    vecs[6]  = '{a: 256'd5,          p: p1 << 4,   m: 259'h3,             lat: 5,   plain: 1'b0};
    vecs[7]  = '{a: 256'd5,          p: p1 << 4,   m: 259'hD,             lat: 5,   plain: 1'b1};
    vecs[8]  = '{a: 256'd7,          p: 260'd11,   m: 259'h1,             lat: 4,   plain: 1'b0};
    vecs[9]  = '{a: 256'hFF,         p: p1 << 16,  m: 259'h101,           lat: 17,  plain: 1'b0};
    vecs[10] = '{a: 256'd2,          p: p1 << 4,   m: 259'hF,             lat: 5,   plain: 1'b0};
    vecs[11] = '{a: 256'd3,          p: 260'd1,    m: '0,                 lat: 1,   plain: 1'b0};
    vecs[12] = '{a: 256'd1,          p: p1 << 259, m: 259'h1,             lat: 260, plain: 1'b1};

    rstn  = 1'b0;
    en1   = 1'b0;
    en0   = 1'b0;
    a_in  = '0;
    p_in  = '0;
    ready = 1'b0;
    use0  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_v("reset valid1", {{(ODW-1){1'b0}}, valid1}, '0);
    check_v("reset mb1", mb1, '0);
    check_v("reset valid0", {{(ODW-1){1'b0}}, valid0}, '0);
    check_v("reset mb0", mb0, '0);
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      use0 = vecs[i].plain;
      run_op(vecs[i].a, vecs[i].p, res, cyc);
      check_v($sformatf("v%0d result", i), res, vecs[i].m);
      check_i($sformatf("v%0d latency", i), cyc, vecs[i].lat);
      accept($sformatf("v%0d accept", i));
    end

    // Downstream stall in DONE: output must hold steady until accepted.
    use0 = 1'b0;
    run_op(256'd3, p1 << 8, res, cyc);
    check_v("stall result", res, 259'h55);
    held   = res;
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (!obs_valid || obs_mb !== held) stable = 1'b0;
    end
    check_i("stall hold", int'(stable), 1);
    accept("stall accept");

    // Reset pulse mid-CALC: immediate clear, no late result, clean restart.
    a_in = 256'd1;
    p_in = p1 << 259;
    en1  = 1'b1;
    @(posedge clk); #1;
    en1 = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_v("abort valid", {{(ODW-1){1'b0}}, valid1}, '0);
    check_v("abort mb", mb1, '0);
    #2;
    rstn = 1'b1;
    seen = 1'b0;
    repeat (300) begin
      @(posedge clk); #1;
      if (valid1) seen = 1'b1;
    end
    check_i("abort no result", int'(seen), 0);
    run_op(256'd5, p1 << 4, res, cyc);
    check_v("restart result", res, 259'h3);
    check_i("restart latency", cyc, 5);
    accept("restart accept");

    // i_en held high, inputs changed during CALC: latched values used, then back-to-back start.
    a_in = 256'd3;
    p_in = p1 << 8;
    en1  = 1'b1;
    @(posedge clk); #1;
    a_in = 256'd5;
    p_in = p1 << 4;
    cyc  = 0;
    while (!valid1 && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_v("b2b first result", mb1, 259'h55);
    check_i("b2b first latency", cyc, 9);
    accept("b2b first accept");
    @(posedge clk); #1;
    en1 = 1'b0;
    cyc = 0;
    while (!valid1 && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_v("b2b second result", mb1, 259'h3);
    check_i("b2b second latency", cyc, 5);
    accept("b2b second accept");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
